debug_clock_stepper: RTL and testbench

Debug clock generator for the processor core. It runs off the 50 MHz board clock and drives the core clock in one of three modes: free-running at a run-time programmable frequency, single-step from a debounced push button, or halted. It replaces the fixed divider on debug builds. It also exports a rising-edge tick, a busy flag and an executed-cycle counter for the display logic.

---
 rtl/debug_clock_stepper.sv | 159 +++++++++++++++
 tb/tb_debug_clock_stepper.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_clock_stepper.sv
`default_nettype none
// ============================================================================
// Module      : debug_clock_stepper
// Description : Debug core-clock generator. Free-runs at a programmable
//               half-period, single-steps one full period per debounced
//               button press, or halts low. Exports a rising-edge tick,
//               a busy flag and a rising-edge counter.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_clock_stepper #(
    parameter int COUNTER_WIDTH  = 18,
    parameter int DEBOUNCE_WIDTH = 20,
    parameter int CYCLE_WIDTH    = 16
) (
    input  logic                     IN_50Mhz,
    input  logic                     RESET,
    input  logic [1:0]               MODE,
    input  logic [COUNTER_WIDTH-1:0] DIVISOR,
    input  logic                     STEP_BUTTON,
    output logic                     OUT_CLK,
    output logic                     OUT_TICK,
    output logic                     BUSY,
    output logic [CYCLE_WIDTH-1:0]   CYCLE_COUNT
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_HIGH      = 2'd1;
    localparam logic [1:0] c_LOW       = 2'd2;
    localparam logic [1:0] c_MODE_RUN  = 2'b01;
    localparam logic [1:0] c_MODE_STEP = 2'b10;

    localparam logic [COUNTER_WIDTH-1:0]  c_CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DEBOUNCE_WIDTH-1:0] c_DEB_ONE = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_WIDTH-1:0]    c_CYC_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_deb;
    logic                      r_deb_d;
    logic [DEBOUNCE_WIDTH-1:0] r_deb_cnt;
    logic                      r_step_req;

    logic [1:0]                r_state;
    logic [COUNTER_WIDTH-1:0]  r_counter;
    logic [COUNTER_WIDTH-1:0]  r_div;
    logic                      r_out_clk;
    logic                      r_out_tick;
    logic [CYCLE_WIDTH-1:0]    r_cycle_count;

    logic                      w_idle_start;
    logic                      w_phase_done;

    // A step request only counts when it lands in IDLE with step mode selected;
    // anywhere else it is simply dropped.
    assign w_idle_start = (MODE == c_MODE_RUN) || ((MODE == c_MODE_STEP) && r_step_req);
    assign w_phase_done = (r_counter == r_div);

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge IN_50Mhz or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= STEP_BUTTON;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: the level flips only after 2^DEBOUNCE_WIDTH consecutive differing cycles.
    always_ff @(posedge IN_50Mhz or posedge RESET) begin
        if (RESET) begin
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_deb) begin
            r_deb_cnt <= '0;
        end else if (&r_deb_cnt) begin
            r_deb     <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
        end
    end

    // One-cycle step request on each debounced rising edge.
    always_ff @(posedge IN_50Mhz or posedge RESET) begin
        if (RESET) begin
            r_deb_d    <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_deb_d    <= r_deb;
            r_step_req <= r_deb & ~r_deb_d;
        end
    end

    // Clock FSM: phases always run to completion so the output never produces runts.
    always_ff @(posedge IN_50Mhz or posedge RESET) begin
        if (RESET) begin
            r_state       <= c_IDLE;
            r_counter     <= '0;
            r_div         <= '0;
            r_out_clk     <= 1'b0;
            r_out_tick    <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_out_tick <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_counter <= '0;
                    r_out_clk <= 1'b0;
                    if (w_idle_start) begin
                        r_state       <= c_HIGH;
                        r_div         <= DIVISOR;
                        r_out_clk     <= 1'b1;
                        r_out_tick    <= 1'b1;
                        r_cycle_count <= r_cycle_count + c_CYC_ONE;
                    end
                end
                c_HIGH: begin
                    if (w_phase_done) begin
                        r_state   <= c_LOW;
                        r_counter <= '0;
                        r_out_clk <= 1'b0;
                        r_div     <= DIVISOR;
                    end else begin
                        r_counter <= r_counter + c_CNT_ONE;
                    end
                end
                c_LOW: begin
                    if (w_phase_done) begin
                        r_counter <= '0;
                        if (MODE == c_MODE_RUN) begin
                            r_state       <= c_HIGH;
                            r_div         <= DIVISOR;
                            r_out_clk     <= 1'b1;
                            r_out_tick    <= 1'b1;
                            r_cycle_count <= r_cycle_count + c_CYC_ONE;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_counter <= r_counter + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_counter <= '0;
                    r_out_clk <= 1'b0;
                end
            endcase
        end
    end

    assign OUT_CLK     = r_out_clk;
    assign OUT_TICK    = r_out_tick;
    assign BUSY        = (r_state != c_IDLE);
    assign CYCLE_COUNT = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_debug_clock_stepper.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_clock_stepper
// Description : Directed self-checking bench for debug_clock_stepper
//               (DEBOUNCE_WIDTH=4, CYCLE_WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_clock_stepper;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [17:0] divisor;
    logic        step_button;
    logic        out_clk;
    logic        out_tick;
    logic        busy;
    logic [3:0]  cycle_count;

    int n_checks = 0;
    int n_pass   = 0;

    debug_clock_stepper #(
        .COUNTER_WIDTH (18),
        .DEBOUNCE_WIDTH(4),
        .CYCLE_WIDTH   (4)
    ) u_dut (
        .IN_50Mhz   (clk),
        .RESET      (rst),
        .MODE       (mode),
        .DIVISOR    (divisor),
        .STEP_BUTTON(step_button),
        .OUT_CLK    (out_clk),
        .OUT_TICK   (out_tick),
        .BUSY       (busy),
        .CYCLE_COUNT(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one source cycle; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mode        = 2'b00;
        divisor     = '0;
        step_button = 1'b0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 2'b00;
        divisor = '0;
        step_button = 1'b0;
        #2;
        tick();
        tick();
        n_checks++; if (out_clk !== 1'b0) $display("FAIL reset_clk: got %b expected 0", out_clk); else n_pass++;
        n_checks++; if (out_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", out_tick); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (cycle_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", cycle_count); else n_pass++;
        rst = 1'b0;
    endtask

    // DIVISOR=3: 4 high, 4 low, first rise one cycle after MODE=01.
    task automatic test_run();
        logic       e_clk;
        logic       e_tick;
        logic [3:0] e_cc;
        do_reset();
        divisor = 18'd3;
        mode    = 2'b01;
        for (int k = 0; k < 24; k++) begin
            tick();
            e_clk  = (k % 8) < 4;
            e_tick = (k % 8) == 0;
            e_cc   = 4'((k / 8) + 1);
            n_checks++; if (out_clk !== e_clk) $display("FAIL run_clk[%0d]: got %b expected %b", k, out_clk, e_clk); else n_pass++;
            n_checks++; if (out_tick !== e_tick) $display("FAIL run_tick[%0d]: got %b expected %b", k, out_tick, e_tick); else n_pass++;
            n_checks++; if (cycle_count !== e_cc) $display("FAIL run_count[%0d]: got %0d expected %0d", k, cycle_count, e_cc); else n_pass++;
        end
    endtask

    // DIVISOR=0: toggle every cycle; 34 samples also cover the 4-bit count wrap.
    task automatic test_max_freq();
        logic       e_clk;
        logic [3:0] e_cc;
        do_reset();
        divisor = 18'd0;
        mode    = 2'b01;
        for (int k = 0; k < 34; k++) begin
            tick();
            e_clk = (k % 2) == 0;
            e_cc  = 4'((k / 2) + 1);
            n_checks++; if (out_clk !== e_clk) $display("FAIL max_clk[%0d]: got %b expected %b", k, out_clk, e_clk); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL max_busy[%0d]: got %b expected 1", k, busy); else n_pass++;
            n_checks++; if (cycle_count !== e_cc) $display("FAIL max_count[%0d]: got %0d expected %0d", k, cycle_count, e_cc); else n_pass++;
            if (k == 31) begin
                n_checks++; if (cycle_count !== 4'd0) $display("FAIL wrap_count: got %0d expected 0", cycle_count); else n_pass++;
            end
        end
    endtask

    task automatic test_step();
        int first_rise;
        int n_high;
        int n_busy;
        int n_ticks;
        int n_wait;
        do_reset();
        divisor     = 18'd2;
        mode        = 2'b10;
        first_rise  = -1;
        n_high      = 0;
        n_busy      = 0;
        n_ticks     = 0;
        step_button = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (out_clk && first_rise < 0) first_rise = i + 1;
            if (out_clk) n_high++;
            if (busy) n_busy++;
            if (out_tick) n_ticks++;
            if (i == 39) step_button = 1'b0;
        end
        n_checks++; if (first_rise !== 20) $display("FAIL step_latency: got %0d expected 20", first_rise); else n_pass++;
        n_checks++; if (n_high !== 3) $display("FAIL step_high: got %0d expected 3", n_high); else n_pass++;
        n_checks++; if (n_busy !== 6) $display("FAIL step_busy: got %0d expected 6", n_busy); else n_pass++;
        n_checks++; if (n_ticks !== 1) $display("FAIL step_ticks: got %0d expected 1", n_ticks); else n_pass++;
        n_checks++; if (cycle_count !== 4'd1) $display("FAIL step_count: got %0d expected 1", cycle_count); else n_pass++;

        // Short glitch never survives the debouncer.
        repeat (10) tick();
        step_button = 1'b1;
        repeat (5) tick();
        step_button = 1'b0;
        n_ticks = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_tick) n_ticks++;
        end
        n_checks++; if (n_ticks !== 0) $display("FAIL glitch_ticks: got %0d expected 0", n_ticks); else n_pass++;
        n_checks++; if (cycle_count !== 4'd1) $display("FAIL glitch_count: got %0d expected 1", cycle_count); else n_pass++;

        // Release/press while BUSY (period 42) is discarded.
        divisor     = 18'd20;
        step_button = 1'b1;
        n_wait      = 0;
        while (!out_clk && n_wait < 40) begin
            tick();
            n_wait++;
        end
        n_checks++; if (out_clk !== 1'b1) $display("FAIL busy_step_start: got %b expected 1", out_clk); else n_pass++;
        step_button = 1'b0;
        repeat (20) tick();
        step_button = 1'b1;
        n_ticks = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_tick) n_ticks++;
        end
        n_checks++; if (n_ticks !== 0) $display("FAIL busy_step_extra: got %0d expected 0", n_ticks); else n_pass++;
        n_checks++; if (cycle_count !== 4'd2) $display("FAIL busy_step_count: got %0d expected 2", cycle_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_step_idle: got %b expected 0", busy); else n_pass++;
        step_button = 1'b0;
    endtask

    // DIVISOR=5, halt after 2 high cycles: 6 high + 6 low then stay idle low.
    task automatic test_halt_drain();
        logic e_clk;
        logic e_busy;
        do_reset();
        divisor = 18'd5;
        mode    = 2'b01;
        tick();
        tick();
        mode = 2'b00;
        for (int k = 2; k < 30; k++) begin
            tick();
            e_clk  = k < 6;
            e_busy = k < 12;
            n_checks++; if (out_clk !== e_clk) $display("FAIL halt_clk[%0d]: got %b expected %b", k, out_clk, e_clk); else n_pass++;
            n_checks++; if (busy !== e_busy) $display("FAIL halt_busy[%0d]: got %b expected %b", k, busy, e_busy); else n_pass++;
        end
        n_checks++; if (cycle_count !== 4'd1) $display("FAIL halt_count: got %0d expected 1", cycle_count); else n_pass++;
    endtask

    // DIVISOR 3->7 mid-high: current high stays 4, later phases are 8.
    task automatic test_divisor_change();
        logic e_clk;
        do_reset();
        divisor = 18'd3;
        mode    = 2'b01;
        tick();
        n_checks++; if (out_clk !== 1'b1) $display("FAIL div_first: got %b expected 1", out_clk); else n_pass++;
        tick();
        divisor = 18'd7;
        for (int k = 2; k < 28; k++) begin
            if (k > 2) tick();
            else tick();
            e_clk = (k < 4) || ((k >= 12) && (k < 20));
            n_checks++; if (out_clk !== e_clk) $display("FAIL div_clk[%0d]: got %b expected %b", k, out_clk, e_clk); else n_pass++;
        end
    endtask

    // Reset pulse mid-low clears outputs immediately; run resumes one cycle after release.
    task automatic test_reset_mid();
        do_reset();
        divisor = 18'd3;
        mode    = 2'b01;
        repeat (6) tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rmid_pre_busy: got %b expected 1", busy); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (out_clk !== 1'b0) $display("FAIL rmid_clk: got %b expected 0", out_clk); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (cycle_count !== 4'd0) $display("FAIL rmid_count: got %0d expected 0", cycle_count); else n_pass++;
        n_checks++; if (out_tick !== 1'b0) $display("FAIL rmid_tick: got %b expected 0", out_tick); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (out_clk !== 1'b1) $display("FAIL rmid_restart_clk: got %b expected 1", out_clk); else n_pass++;
        n_checks++; if (cycle_count !== 4'd1) $display("FAIL rmid_restart_count: got %0d expected 1", cycle_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_max_freq();
        test_step();
        test_halt_drain();
        test_divisor_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
